slv_rdwr_scheduler: RTL and testbench

- Control-only scheduler on the crossbar side of a slave port, ahead of the slave clock-domain-crossing stage.
- Serializes read and write traffic for slaves that cannot run both concurrently. Only reads or only writes are in flight at any time.
- Bounds outstanding transactions per direction, gates W beats until their AW is accepted, and applies round-robin fairness with a per-grant burst limit.
- Payload buses bypass this block. It only gates VALID/READY and observes the LEN, LAST and response handshakes.

---
 rtl/slv_rdwr_scheduler.sv | 262 ++++++++++++++++++++++++++
 tb/tb_slv_rdwr_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slv_rdwr_scheduler.sv
// slv_rdwr_scheduler
// Control-only read/write serializer on the crossbar side of a slave port.
// Lets only one direction have bursts in flight at a time, caps the number
// of outstanding bursts per direction, holds W beats until their AW has been
// accepted, and alternates directions fairly with a per-grant burst limit.
// Payload buses bypass this block; only VALID/READY are gated here.
//
// Build option: define SLV_RDWR_SCHED_WLAST_CHECK_EN to build a small AWLEN
// FIFO and beat counter that raise a sticky wlastErr on an early or late
// WLAST. Without the macro, wlastErr is tied low and upAWLEN is unused.

module slv_rdwr_scheduler #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_GRANT       = 4,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 upARVALID,
  output logic                 upARREADY,
  output logic                 dnARVALID,
  input  logic                 dnARREADY,
  input  logic                 upAWVALID,
  input  logic [7:0]           upAWLEN,
  output logic                 upAWREADY,
  output logic                 dnAWVALID,
  input  logic                 dnAWREADY,
  input  logic                 upWVALID,
  input  logic                 upWLAST,
  output logic                 upWREADY,
  output logic                 dnWVALID,
  input  logic                 dnWREADY,
  input  logic                 RVALID,
  input  logic                 RREADY,
  input  logic                 RLAST,
  input  logic                 BVALID,
  input  logic                 BREADY,
  output logic [2:0]           schedState,
  output logic [CNT_WIDTH-1:0] rdOutstanding,
  output logic [CNT_WIDTH-1:0] wrOutstanding,
  output logic                 wlastErr
);

  localparam logic [CNT_WIDTH-1:0] MAX_OUT_C   = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [7:0]           MAX_GRANT_C = 8'(MAX_GRANT);
  localparam logic                 RR_READ     = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_DRAIN_RD = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DRAIN_WR = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]   w_bursts_q, w_bursts_d;
  logic [7:0]             grant_cnt_q, grant_cnt_d;

  logic ar_en, aw_en, w_en;
  logic ar_hs, aw_hs, w_hs, wlast_hs, rlast_hs, b_hs;

  // Up/down counter that holds at zero when asked to decrement from empty.
  function automatic logic [CNT_WIDTH-1:0] cnt_upd(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 inc,
    input logic                 dec
  );
    logic [CNT_WIDTH-1:0] res;
    case ({inc, dec})
      2'b10:   res = cnt + CNT_WIDTH'(1);
      2'b01:   res = (cnt == '0) ? cnt : cnt - CNT_WIDTH'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  // Output decode: VALID/READY gating derived from the registered state.
  always_comb begin
    ar_en     = (state_q == ST_READ)  && (rd_cnt_q < MAX_OUT_C);
    aw_en     = (state_q == ST_WRITE) && (wr_cnt_q < MAX_OUT_C);
    w_en      = (w_bursts_q != '0);
    dnARVALID = upARVALID & ar_en;
    upARREADY = dnARREADY & ar_en;
    dnAWVALID = upAWVALID & aw_en;
    upAWREADY = dnAWREADY & aw_en;
    dnWVALID  = upWVALID & w_en;
    upWREADY  = dnWREADY & w_en;
  end

  assign ar_hs    = upARVALID & dnARREADY & ar_en;
  assign aw_hs    = upAWVALID & dnAWREADY & aw_en;
  assign w_hs     = upWVALID & dnWREADY & w_en;
  assign wlast_hs = w_hs & upWLAST;
  assign rlast_hs = RVALID & RREADY & RLAST;
  assign b_hs     = BVALID & BREADY;

  assign schedState    = state_q;
  assign rdOutstanding = rd_cnt_q;
  assign wrOutstanding = wr_cnt_q;

  // Next-state logic: direction arbitration, drain and round-robin pointer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (upARVALID && upAWVALID) begin
          state_d  = (rr_ptr_q == RR_READ) ? ST_READ : ST_WRITE;
          rr_ptr_d = ~rr_ptr_q;
        end else if (upARVALID) begin
          state_d = ST_READ;
        end else if (upAWVALID) begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        if (upAWVALID && (!upARVALID || (grant_cnt_q == MAX_GRANT_C))) begin
          state_d = ST_DRAIN_RD;
        end else if (!upARVALID && !upAWVALID && (rd_cnt_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN_RD: begin
        if (rd_cnt_q == '0) begin
          state_d  = ST_WRITE;
          rr_ptr_d = RR_READ;
        end
      end
      ST_WRITE: begin
        if (upARVALID && (!upAWVALID || (grant_cnt_q == MAX_GRANT_C))) begin
          state_d = ST_DRAIN_WR;
        end else if (!upARVALID && !upAWVALID && (wr_cnt_q == '0) &&
                     (w_bursts_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN_WR: begin
        if ((wr_cnt_q == '0) && (w_bursts_q == '0)) begin
          state_d = upARVALID ? ST_READ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter updates: outstanding bursts, pending W bursts and grant length.
  always_comb begin
    rd_cnt_d    = cnt_upd(rd_cnt_q, ar_hs, rlast_hs);
    wr_cnt_d    = cnt_upd(wr_cnt_q, aw_hs, b_hs);
    w_bursts_d  = cnt_upd(w_bursts_q, aw_hs, wlast_hs);
    grant_cnt_d = grant_cnt_q;
    if ((state_d != state_q) && ((state_d == ST_READ) || (state_d == ST_WRITE))) begin
      grant_cnt_d = '0;
    end else if ((ar_hs || aw_hs) && (grant_cnt_q != MAX_GRANT_C)) begin
      grant_cnt_d = grant_cnt_q + 8'd1;
    end
  end

  // State register and round-robin pointer.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= RR_READ;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Counter registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      w_bursts_q  <= '0;
      grant_cnt_q <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      w_bursts_q  <= w_bursts_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

`ifdef SLV_RDWR_SCHED_WLAST_CHECK_EN
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [7:0]           fifo_mem_q [MAX_OUTSTANDING];
  logic [7:0]           fifo_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [7:0]           beat_q, beat_d;
  logic                 wlast_err_q, wlast_err_d;
  logic                 fifo_push, fifo_pop;
  logic [7:0]           head_len;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_push = aw_hs && (fifo_cnt_q != MAX_OUT_C);
  assign fifo_pop  = wlast_hs && (fifo_cnt_q != '0);
  assign head_len  = fifo_mem_q[rd_ptr_q];

  // AWLEN FIFO and beat counter; flag any WLAST not on beat AWLEN.
  always_comb begin
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = cnt_upd(fifo_cnt_q, fifo_push, fifo_pop);
    beat_d      = beat_q;
    wlast_err_d = wlast_err_q;
    if (fifo_push) begin
      fifo_mem_d[wr_ptr_q] = upAWLEN;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (fifo_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (w_hs) begin
      beat_d = upWLAST ? 8'd0 : beat_q + 8'd1;
      if ((fifo_cnt_q != '0) && (upWLAST != (beat_q == head_len))) begin
        wlast_err_d = 1'b1;
      end
    end
  end

  // AWLEN storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge ACLK) begin
    fifo_mem_q <= fifo_mem_d;
  end

  // FIFO pointers, beat counter and sticky error flag.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      beat_q      <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      beat_q      <= beat_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  assign wlastErr = wlast_err_q;
`else
  logic unused_awlen;
  assign unused_awlen = ^upAWLEN;
  assign wlastErr     = 1'b0;
`endif

endmodule

// File: tb/tb_slv_rdwr_scheduler.sv
// Directed bench for slv_rdwr_scheduler (default parameters 4/4/4).
module tb_slv_rdwr_scheduler;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic       upARVALID, upARREADY, dnARVALID, dnARREADY;
  logic       upAWVALID, upAWREADY, dnAWVALID, dnAWREADY;
  logic [7:0] upAWLEN;
  logic       upWVALID, upWLAST, upWREADY, dnWVALID, dnWREADY;
  logic       RVALID, RREADY, RLAST, BVALID, BREADY;
  logic [2:0] schedState;
  logic [3:0] rdOutstanding, wrOutstanding;
  logic       wlastErr;

`ifdef SLV_RDWR_SCHED_WLAST_CHECK_EN
  localparam int WCHK = 1;
`else
  localparam int WCHK = 0;
`endif

  int vecs = 0;
  int errs = 0;

  slv_rdwr_scheduler #(
    .MAX_OUTSTANDING(4),
    .MAX_GRANT(4),
    .CNT_WIDTH(4)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .upARVALID(upARVALID), .upARREADY(upARREADY),
    .dnARVALID(dnARVALID), .dnARREADY(dnARREADY),
    .upAWVALID(upAWVALID), .upAWLEN(upAWLEN), .upAWREADY(upAWREADY),
    .dnAWVALID(dnAWVALID), .dnAWREADY(dnAWREADY),
    .upWVALID(upWVALID), .upWLAST(upWLAST), .upWREADY(upWREADY),
    .dnWVALID(dnWVALID), .dnWREADY(dnWREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .BVALID(BVALID), .BREADY(BREADY),
    .schedState(schedState), .rdOutstanding(rdOutstanding),
    .wrOutstanding(wrOutstanding), .wlastErr(wlastErr)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    upARVALID = 1'b1; dnARREADY = 1'b1;
    upAWVALID = 1'b1; dnAWREADY = 1'b1; upAWLEN = 8'd0;
    upWVALID = 1'b1; upWLAST = 1'b1; dnWREADY = 1'b1;
    RVALID = 1'b0; RREADY = 1'b1; RLAST = 1'b1;
    BVALID = 1'b0; BREADY = 1'b1;

    // Reset with every VALID high: everything gated off
    tick(); tick();
    chk("rst_state", 32'(schedState), 0);
    chk("rst_dnARVALID", 32'(dnARVALID), 0);
    chk("rst_upARREADY", 32'(upARREADY), 0);
    chk("rst_dnAWVALID", 32'(dnAWVALID), 0);
    chk("rst_upAWREADY", 32'(upAWREADY), 0);
    chk("rst_dnWVALID", 32'(dnWVALID), 0);
    chk("rst_upWREADY", 32'(upWREADY), 0);
    chk("rst_rdcnt", 32'(rdOutstanding), 0);
    chk("rst_wrcnt", 32'(wrOutstanding), 0);
    chk("rst_wlasterr", 32'(wlastErr), 0);

    // Release with both requests: read wins first
    ARESETN = 1'b1; dnARREADY = 1'b0; upWVALID = 1'b0;
    tick();
    chk("rel_state_read", 32'(schedState), 1);
    chk("rel_dnARVALID", 32'(dnARVALID), 1);
    chk("rel_upARREADY", 32'(upARREADY), 0);
    chk("rel_dnAWVALID", 32'(dnAWVALID), 0);

    // Read outstanding limit
    upAWVALID = 1'b0; dnARREADY = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("lim_arready", 32'(upARREADY), (i < 4) ? 1 : 0);
      tick();
    end
    chk("lim_rdcnt4", 32'(rdOutstanding), 4);
    chk("lim_state", 32'(schedState), 1);
    RVALID = 1'b1;
    #1;
    chk("lim_arready_full", 32'(upARREADY), 0);
    tick();
    RVALID = 1'b0;
    #1;
    chk("lim_rdcnt3", 32'(rdOutstanding), 3);
    chk("lim_fifth_ar", 32'(upARREADY), 1);
    tick();
    upARVALID = 1'b0;
    #1;
    chk("lim_rdcnt_back4", 32'(rdOutstanding), 4);
    chk("lim_arready_again0", 32'(upARREADY), 0);

    // Switch read -> write through DRAIN_RD
    RVALID = 1'b1;
    tick(); tick();
    RVALID = 1'b0;
    #1;
    chk("sw_rdcnt2", 32'(rdOutstanding), 2);
    chk("sw_state_read", 32'(schedState), 1);
    upAWVALID = 1'b1; upAWLEN = 8'd2; dnAWREADY = 1'b0;
    #1;
    chk("sw_aw_blocked_read", 32'(dnAWVALID), 0);
    tick();
    chk("sw_state_drain", 32'(schedState), 2);
    chk("sw_aw_blocked_drain", 32'(dnAWVALID), 0);
    RVALID = 1'b1;
    tick(); tick();
    RVALID = 1'b0;
    #1;
    chk("sw_drain_rdcnt0", 32'(rdOutstanding), 0);
    chk("sw_still_drain", 32'(schedState), 2);
    chk("sw_aw_blocked_last", 32'(dnAWVALID), 0);
    tick();
    chk("sw_state_write", 32'(schedState), 3);

    // W ahead of its AW stalls
    upWVALID = 1'b1; upWLAST = 1'b0;
    #1;
    chk("w_early_wready", 32'(upWREADY), 0);
    chk("w_early_dnwvalid", 32'(dnWVALID), 0);
    chk("w_dnawvalid", 32'(dnAWVALID), 1);
    tick();
    chk("w_early_wready2", 32'(upWREADY), 0);
    dnAWREADY = 1'b1;
    #1;
    chk("w_awready", 32'(upAWREADY), 1);
    tick();
    upAWVALID = 1'b0;
    #1;
    chk("w_pass_wready", 32'(upWREADY), 1);
    chk("w_pass_dnwvalid", 32'(dnWVALID), 1);
    chk("w_wrcnt1", 32'(wrOutstanding), 1);
    tick(); tick();
    upWLAST = 1'b1;
    #1;
    chk("w_last_wready", 32'(upWREADY), 1);
    tick();
    chk("w_done_wready", 32'(upWREADY), 0);
    chk("w_done_wlasterr", 32'(wlastErr), 0);
    chk("w_done_wrcnt", 32'(wrOutstanding), 1);
    chk("w_done_state", 32'(schedState), 3);
    upWVALID = 1'b0; upWLAST = 1'b0; BVALID = 1'b1;
    tick();
    BVALID = 1'b0;
    #1;
    chk("w_b_wrcnt0", 32'(wrOutstanding), 0);
    chk("w_b_state", 32'(schedState), 3);
    tick();
    chk("w_idle", 32'(schedState), 0);

    // Fairness: both directions continuously requesting
    upAWLEN = 8'd0; upARVALID = 1'b1; upAWVALID = 1'b1;
    tick();
    chk("fair_state_read", 32'(schedState), 1);
    for (int i = 0; i < 4; i++) begin
      chk("fair_ar_grant", 32'(upARREADY), 1);
      chk("fair_no_wr", 32'(wrOutstanding), 0);
      tick();
    end
    chk("fair_rdcnt4", 32'(rdOutstanding), 4);
    chk("fair_ar_stop", 32'(upARREADY), 0);
    chk("fair_aw_wait", 32'(upAWREADY), 0);
    tick();
    chk("fair_drain_rd", 32'(schedState), 2);
    RVALID = 1'b1;
    tick(); tick(); tick(); tick();
    RVALID = 1'b0;
    #1;
    chk("fair_rd_empty", 32'(rdOutstanding), 0);
    chk("fair_drain_rd2", 32'(schedState), 2);
    chk("fair_aw_wait2", 32'(upAWREADY), 0);
    tick();
    chk("fair_state_write", 32'(schedState), 3);
    for (int i = 0; i < 4; i++) begin
      chk("fair_aw_grant", 32'(upAWREADY), 1);
      chk("fair_ar_blocked", 32'(upARREADY), 0);
      chk("fair_no_rd", 32'(rdOutstanding), 0);
      tick();
    end
    chk("fair_wrcnt4", 32'(wrOutstanding), 4);
    chk("fair_aw_stop", 32'(upAWREADY), 0);
    tick();
    chk("fair_drain_wr", 32'(schedState), 4);
    chk("fair_ar_wait", 32'(upARREADY), 0);
    upWVALID = 1'b1; upWLAST = 1'b1; BVALID = 1'b1;
    tick(); tick(); tick(); tick();
    upWVALID = 1'b0; upWLAST = 1'b0; BVALID = 1'b0;
    #1;
    chk("fair_wr_empty", 32'(wrOutstanding), 0);
    chk("fair_drain_wr2", 32'(schedState), 4);
    chk("fair_w_closed", 32'(upWREADY), 0);
    tick();
    chk("fair_back_read", 32'(schedState), 1);
    chk("fair_ar_again", 32'(upARREADY), 1);
    chk("fair_wlasterr", 32'(wlastErr), 0);

    // Reset in the middle of a read burst
    upAWVALID = 1'b0;
    tick(); tick();
    chk("mid_rdcnt2", 32'(rdOutstanding), 2);
    ARESETN = 1'b0;
    tick();
    chk("mid_state", 32'(schedState), 0);
    chk("mid_rdcnt", 32'(rdOutstanding), 0);
    chk("mid_arready", 32'(upARREADY), 0);

    // Early WLAST on a 4-beat burst
    ARESETN = 1'b1; upARVALID = 1'b0; upAWVALID = 1'b1; upAWLEN = 8'd3;
    tick();
    chk("wl_state_write", 32'(schedState), 3);
    chk("wl_awready", 32'(upAWREADY), 1);
    tick();
    upAWVALID = 1'b0; upWVALID = 1'b1; upWLAST = 1'b0;
    tick();
    upWLAST = 1'b1;
    tick();
    upWVALID = 1'b0; upWLAST = 1'b0;
    #1;
    chk("wl_err_set", 32'(wlastErr), 32'(WCHK));
    chk("wl_wready", 32'(upWREADY), 0);
    BVALID = 1'b1;
    tick();
    BVALID = 1'b0;
    tick(); tick();
    chk("wl_err_sticky", 32'(wlastErr), 32'(WCHK));
    chk("wl_idle", 32'(schedState), 0);
    ARESETN = 1'b0;
    tick();
    chk("wl_err_cleared", 32'(wlastErr), 0);
    ARESETN = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
